// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for gate_vector_checker: op encodings, FSM states and
// the reference truth function for every supported gate type.
package gate_chk_pkg;

  localparam logic [2:0] OP_BUF  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // mask marks the live input bits; unused bits are neutralised per reduction
  function automatic logic gate_expected(input logic [2:0] op,
                                         input logic [7:0] vec,
                                         input logic [7:0] mask);
    logic all1, any1, par;
    all1 = &(vec | ~mask);
    any1 = |(vec & mask);
    par  = ^(vec & mask);
    case (op)
      OP_BUF:  return vec[0];
      OP_NOT:  return ~vec[0];
      OP_AND:  return all1;
      OP_OR:   return any1;
      OP_NAND: return ~all1;
      OP_NOR:  return ~any1;
      OP_XOR:  return par;
      OP_XNOR: return ~par;
      default: return vec[0];
    endcase
  endfunction

endpackage

// File: rtl/gate_vector_checker_ref_model.sv
// Combinational golden gate: expected output bit for the latched op and the
// vector currently applied to the gate under test.
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            exp_o
);

  localparam logic [8:0] MASK_W = (9'd1 << N_IN) - 9'd1;
  localparam logic [7:0] MASK   = MASK_W[7:0];

  logic [7:0] vec_ext;

  always_comb begin
    vec_ext = '0;
    vec_ext[N_IN-1:0] = vec_i;
  end

  assign exp_o = gate_expected(op_i, vec_ext, MASK);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus/check engine for a single-output gate under test.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN:0]   ERR_MAX     = {1'b1, {N_IN{1'b0}}};
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] din_q, din_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic [N_IN:0]   err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            found_q, found_d;
  logic            pass_q, pass_d;
  logic            exp_bit, mismatch, last_check;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .op_i  (op_q),
    .vec_i (vec_q),
    .exp_o (exp_bit)
  );

  // case-inequality so an undriven or X gate output never passes in simulation
  assign mismatch = (dut_out !== exp_bit);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign last_check = (vec_q == VEC_LAST) || mismatch;
`else
  assign last_check = (vec_q == VEC_LAST);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    din_d   = din_q;
    ffv_d   = ffv_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          op_d    = op;
          vec_d   = '0;
          din_d   = '0;
          ffv_d   = '0;
          err_d   = '0;
          found_d = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd1) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!found_q) begin
            ffv_d   = vec_q;
            found_d = 1'b1;
          end
        end
        if (last_check) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 1'b1;
          din_d   = vec_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      vec_q   <= '0;
      din_q   <= '0;
      ffv_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      din_q   <= din_d;
      ffv_q   <= ffv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in         = din_q;
  assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Self-checking stimulus engine for the single-output logic gates in the library: the driving and checking end of a gate's a→y interface.
- On start, sweeps all 2^N_IN input combinations into a gate under test, waits a settle interval, and compares the gate output against a built-in reference for the selected gate type.
- Reports mismatch count, first failing vector and pass/fail.
- Used in simulation harnesses and on-board self-test wrappers around the dataflow, gate-level and behavioural gate modules.

Parameters:
- N_IN, 2: gate input width; sweep covers 0 .. 2^N_IN-1; legal range 1..8.
- SETTLE_CYCLES, 2: cycles held in SETTLE before sampling dut_out; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- op  in  3  gate type, latched at start: 0 BUF, 1 NOT, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
- dut_in  out  N_IN  vector driven to the gate under test
- dut_out  in  1  gate-under-test output
- busy  out  1  high in DRIVE/SETTLE/CHECK
- done  out  1  high in DONE; held until the next accepted start
- pass  out  1  valid while done: 1 iff err_count==0
- err_count  out  N_IN+1  mismatch count; saturates at 2^N_IN
- first_fail_vec  out  N_IN  first mismatching vector; 0 if none

Behaviour:
- Reset (async assert, sync release): state IDLE; dut_in, busy, done, pass, err_count, first_fail_vec all 0; op latch 0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1 → DRIVE. On that edge: latch op; vec=0; clear err_count, first_fail_vec, done, pass; internal first-fail flag cleared.
- DRIVE: dut_in=vec (registered); 1 cycle → SETTLE; settle counter loaded with SETTLE_CYCLES.
- SETTLE: counter decrements; at 1 → CHECK. SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK: compare dut_out with expected(op, vec).
  - Mismatch: err_count+1, saturating.
  - On the first mismatch of the sweep, first_fail_vec=vec.
  - In simulation, X/Z on dut_out counts as a mismatch (case-inequality).
- CHECK exit: vec==2^N_IN-1 → DONE; otherwise vec+1 → DRIVE.
- dut_in holds its value from DRIVE through CHECK. It changes only on DRIVE entry.
- Reference functions:
  - NOT/BUF use vec[0] only.
  - AND/OR/NAND/NOR/XOR/XNOR reduce over all N_IN bits.
  - For N_IN=1, AND=OR=BUF and NAND=NOR=NOT.
- Latency: per vector SETTLE_CYCLES+2 cycles. done rises 2^N_IN*(SETTLE_CYCLES+2) cycles after the start-accept edge.
- DONE: pass=(err_count==0); outputs frozen; dut_in keeps the last vector.
- start while busy is ignored. No restart and no effect on op.
- start held high continuously re-launches a sweep one cycle after each DONE entry.
- rst_n asserted mid-sweep aborts immediately to reset values. No partial results are retained.

Optional Feature:
- Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE with err_count=1 and pass=0; remaining vectors are skipped.
- Undefined: the full sweep always runs; err_count is the total mismatch count.

Decomposition:
- Package gate_chk_pkg:
  - op encoding constants OP_BUF..OP_XNOR (3-bit)
  - FSM state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
  - reference function gate_expected(op, vec)
- One sub-module: gate_ref_model, purely combinational, N_IN-parameterised, instantiated once to produce the expected bit.
- FSM, counters and result registers live in gate_vector_checker.

Test Plan:
- N_IN=1, SETTLE=2, op=NOT, DUT is a correct inverter → done exactly 8 cycles after start accept; pass=1, err_count=0, dut_in sequence 0,1.
- N_IN=1, op=NOT, DUT is a buffer → err_count=2, first_fail_vec=0, pass=0.
- N_IN=2, op=AND, DUT is an OR gate → mismatches at vectors 01 and 10; err_count=2, first_fail_vec=1.
- N_IN=2, op=XOR, correct DUT; rst_n pulsed low during vector 2 SETTLE → all outputs 0 at once. Restart → pass=1 after 16 cycles.
- start pulsed during CHECK of vector 1, plus op changed mid-sweep → no restart; original op used; single done.
- GATE_CHK_STOP_ON_FAIL_EN defined, N_IN=2, op=NAND, DUT is AND → DONE after the vector-0 CHECK (4 cycles after accept); err_count=1, first_fail_vec=0.
